// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide engine.
//   op_e      : operation codes (bit0 = signed, bit1 = divide)
//   S_*       : 2-bit FSM state encodings
//   op_is_*   : decode helpers used by the engine and the decoder
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      OP_MULTU = 2'b00,
      OP_MULT  = 2'b01,
      OP_DIVU  = 2'b10,
      OP_DIV   = 2'b11
   } op_e;

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_FIX  = 2'b10;
   localparam logic [1:0] S_DONE = 2'b11;

   function automatic logic op_is_signed(input logic [1:0] op);
      return op[0];
   endfunction

   function automatic logic op_is_div(input logic [1:0] op);
      return op[1];
   endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response bundle between the core and the multiply/divide engine.
//   start, op, a, b              : request (core -> engine)
//   busy, done, we, hi, lo,
//   div_by_zero                  : status and results (engine -> core/spregfile)
// master = core side, slave = engine side.
interface muldiv_unit_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic             we;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             div_by_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, we, hi, lo, div_by_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, we, hi, lo, div_by_zero
   );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide engine.
//   is_div   : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_in   : 2*WIDTH accumulator
//              mult: {partial product high, remaining multiplier bits}
//              div : {remainder, remaining dividend bits / quotient bits}
//   operand  : multiplicand magnitude (mult) or divisor magnitude (div)
//   acc_out  : accumulator after this iteration
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic               is_div,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [WIDTH-1:0]   operand,
   output logic [2*WIDTH-1:0] acc_out
);

   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff;

   always_comb begin
      sum     = '0;
      shifted = '0;
      diff    = '0;
      acc_out = acc_in;
      if (!is_div) begin
         // LSB of the low half is the current multiplier bit; the carry of
         // the add lands in the top bit as everything shifts right by one.
         sum     = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + (acc_in[0] ? {1'b0, operand} : '0);
         acc_out = {sum, acc_in[WIDTH-1:1]};
      end else begin
         // WIDTH+1 bit trial remainder: old remainder shifted left plus the
         // next dividend bit. Subtraction is only kept when it fits.
         shifted = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
         diff    = shifted[WIDTH-1:0] - operand;
         if (shifted >= {1'b0, operand}) begin
            acc_out = {diff, acc_in[WIDTH-2:0], 1'b1};
         end else begin
            acc_out = {shifted[WIDTH-1:0], acc_in[WIDTH-2:0], 1'b0};
         end
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit multiply/divide engine for MULT/MULTU/DIV/DIVU.
//   clk    : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : muldiv_unit_if.slave
//            start/op/a/b sampled when idle or done
//            busy high in RUN and FIX, done/we pulse for one cycle in DONE
//            hi = product high / remainder, lo = product low / quotient
//            div_by_zero high with done when the divisor was zero
// Latency: done is high in the cycle after the WIDTH+1th edge past the
// accepting edge. hi/lo only change at the FIX edge or on reset.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic         clk,
   input  logic         reset,
   muldiv_unit_if.slave bus
);

   localparam int                 CW      = $clog2(WIDTH);
   localparam logic [CW-1:0]      LAST    = CW'(WIDTH - 1);
   localparam logic [CW-1:0]      CNT_ONE = CW'(1);
   localparam logic [WIDTH-1:0]   ONE_W   = WIDTH'(1);
   localparam logic [2*WIDTH-1:0] ONE_2W  = (2*WIDTH)'(1);

   logic [1:0]         state;
   logic [CW-1:0]      cnt;
   logic               is_div;
   logic               neg_lo;     // product / quotient negate
   logic               neg_hi;     // remainder negate (divide only)
   logic               dz;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   operand;
   logic [WIDTH-1:0]   a_raw;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;

   logic [2*WIDTH-1:0] step_out;
   logic               sa;
   logic               sb;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .is_div  (is_div),
      .acc_in  (acc),
      .operand (operand),
      .acc_out (step_out)
   );

   // Operand magnitudes and signs at the accepting edge.
   always_comb begin
      sa    = op_is_signed(bus.op) & bus.a[WIDTH-1];
      sb    = op_is_signed(bus.op) & bus.b[WIDTH-1];
      mag_a = sa ? (~bus.a + ONE_W) : bus.a;
      mag_b = sb ? (~bus.b + ONE_W) : bus.b;
   end

   // Sign fix-up applied at the FIX edge. A zero divisor bypasses it and
   // reports the raw dividend with an all-ones quotient.
   always_comb begin
      prod   = neg_lo ? (~acc + ONE_2W) : acc;
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
      if (dz) begin
         fix_hi = a_raw;
         fix_lo = '1;
      end else if (is_div) begin
         fix_lo = neg_lo ? (~acc[WIDTH-1:0] + ONE_W) : acc[WIDTH-1:0];
         fix_hi = neg_hi ? (~acc[2*WIDTH-1:WIDTH] + ONE_W) : acc[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         is_div  <= 1'b0;
         neg_lo  <= 1'b0;
         neg_hi  <= 1'b0;
         dz      <= 1'b0;
         acc     <= '0;
         operand <= '0;
         a_raw   <= '0;
         hi_r    <= '0;
         lo_r    <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE: begin
               if (bus.start) begin
                  is_div <= op_is_div(bus.op);
                  neg_lo <= sa ^ sb;
                  neg_hi <= sa;
                  dz     <= op_is_div(bus.op) & (bus.b == '0);
                  a_raw  <= bus.a;
                  cnt    <= '0;
                  // Multiply shifts the multiplier out of the low half;
                  // divide shifts the dividend out of the low half.
                  if (op_is_div(bus.op)) begin
                     acc     <= {{WIDTH{1'b0}}, mag_a};
                     operand <= mag_b;
                  end else begin
                     acc     <= {{WIDTH{1'b0}}, mag_b};
                     operand <= mag_a;
                  end
                  state <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               acc <= step_out;
               cnt <= cnt + CNT_ONE;
               if (cnt == LAST) begin
                  state <= S_FIX;
               end
            end
            S_FIX: begin
               hi_r  <= fix_hi;
               lo_r  <= fix_lo;
               state <= S_DONE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy        = (state == S_RUN) || (state == S_FIX);
   assign bus.done        = (state == S_DONE);
   assign bus.we          = (state == S_DONE);
   assign bus.div_by_zero = (state == S_DONE) & dz;
   assign bus.hi          = hi_r;
   assign bus.lo          = lo_r;

endmodule
